// File: rtl/mux2x1_stream_arbiter_if.sv
// Stream bundle for the two-input round-robin arbiter. The arbiter uses the
// slave modport. The upstream producers and the downstream consumer use the
// master modport.
interface mux2x1_stream_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic             sel;

  // Producer/consumer side: drives input words and downstream ready
  modport master (
    output in0_valid, in0_data, input in0_ready,
    output in1_valid, in1_data, input in1_ready,
    input  out_valid, out_data, out_src, sel,
    output out_ready
  );

  // Arbiter side
  modport slave (
    input  in0_valid, in0_data, output in0_ready,
    input  in1_valid, in1_data, output in1_ready,
    output out_valid, out_data, out_src, sel,
    input  out_ready
  );
endinterface

// File: rtl/mux2x1_stream_arbiter.sv
// Two-input valid/ready round-robin arbiter with a single-entry output
// register. The registered sel tracks out_src so that it can steer a
// downstream 2:1 mux directly. The EMPTY/FULL state is carried by out_valid.
module mux2x1_stream_arbiter #(
  parameter int WIDTH = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  mux2x1_stream_arbiter_if.slave bus
);
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_src_reg;
  logic             sel_reg;
  logic             last_reg;

  logic can_load;
  logic grant0;
  logic grant1;
  logic ready0;
  logic ready1;
  logic accept0;
  logic accept1;

  // Round-robin grant. On a tie, the channel not served last wins.
  // Readies are gated by the free/draining slot and held low during reset.
  always_comb begin
    grant0   = bus.in0_valid && (!bus.in1_valid || last_reg);
    grant1   = bus.in1_valid && (!bus.in0_valid || !last_reg);
    can_load = !out_valid_reg || bus.out_ready;
    ready0   = rst_n && grant0 && can_load;
    ready1   = rst_n && grant1 && can_load;
    accept0  = bus.in0_valid && ready0;
    accept1  = bus.in1_valid && ready1;
  end

  // Output register. It loads on accept, empties on a consume with no
  // refill, and holds while stalled. Priority moves only on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= 1'b0;
      sel_reg       <= 1'b0;
      last_reg      <= 1'b1;
    end else if (accept0 || accept1) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= accept1 ? bus.in1_data : bus.in0_data;
      out_src_reg   <= accept1;
      sel_reg       <= accept1;
      last_reg      <= accept1;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in0_ready = ready0;
  assign bus.in1_ready = ready1;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_src   = out_src_reg;
  assign bus.sel       = sel_reg;
endmodule

// File: tb/tb_mux2x1_stream_arbiter.sv
// Directed bench for mux2x1_stream_arbiter. Inputs change on the falling edge.
// Readies and registered outputs are checked 1 time unit later, well away
// from the rising edge.
module tb_mux2x1_stream_arbiter;
  localparam int W = 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [3:0] obs;   // {out_valid, out_data, out_src, sel}
  logic [1:0] rdy;   // {in0_ready, in1_ready}

  mux2x1_stream_arbiter_if #(.WIDTH(W)) bus ();

  mux2x1_stream_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per input handshake
  always @(posedge clk) begin
    if (rst_n && bus.in0_valid && bus.in0_ready)
      $display("%0t accept ch0 data=%0h", $time, bus.in0_data);
    if (rst_n && bus.in1_valid && bus.in1_ready)
      $display("%0t accept ch1 data=%0h", $time, bus.in1_data);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sample();
    #1;
    obs = {bus.out_valid, bus.out_data, bus.out_src, bus.sel};
    rdy = {bus.in0_ready, bus.in1_ready};
  endtask

  task automatic set_in(input logic v0, input logic d0, input logic v1,
                        input logic d1, input logic ordy);
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.out_ready = ordy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    sample();
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs, 4'b0000);
    end
    checks++;
    if (rdy !== 2'b00) begin
      errors++;
      $display("FAIL reset_readies: got %b want %b", rdy, 2'b00);
    end
  endtask

  task automatic test_single();
    rst_n = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    sample();
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: got %b want %b", rdy, 2'b10);
    end
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL single_pre_out: got %b want %b", obs, 4'b0000);
    end
    tick();
    sample();
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL single_out: got %b want %b", obs, 4'b1100);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    logic [3:0] exp_obs;
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b10 : 2'b01;
      sample();
      checks++;
      if (rdy !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b want %b", k, rdy, exp_rdy);
      end
      tick();
      exp_obs = (k % 2 == 0) ? 4'b1000 : 4'b1111;
      sample();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL rr_out[%0d]: got %b want %b", k, obs, exp_obs);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++;
      if (obs !== 4'b1111 || rdy !== 2'b00) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got out=%b rdy=%b want out=1111 rdy=00",
                 k, obs, rdy);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    sample();
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want %b", rdy, 2'b10);
    end
    tick();
    sample();
    checks++;
    if (obs !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_out: got %b want %b", obs, 4'b1000);
    end
  endtask

  task automatic test_priority_idle();
    do_reset();
    // Serve channel 1, idle, then tie: channel 0 first
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    sample();
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL idle_tie_after_ch1: got %b want %b", rdy, 2'b10);
    end
    // Serve channel 0 only, idle, then tie: channel 1 first
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    sample();
    checks++;
    if (rdy !== 2'b01) begin
      errors++;
      $display("FAIL idle_tie_after_ch0: got %b want %b", rdy, 2'b01);
    end
    tick();
    sample();
    checks++;
    if (obs !== 4'b1111) begin
      errors++;
      $display("FAIL idle_tie_out: got %b want %b", obs, 4'b1111);
    end
  endtask

  task automatic test_drain();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sample();
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL drain_full: got %b want %b", obs, 4'b1100);
    end
    tick();
    sample();
    checks++;
    if (obs !== 4'b0100) begin
      errors++;
      $display("FAIL drain_empty: got %b want %b", obs, 4'b0100);
    end
    tick();
    sample();
    checks++;
    if (obs !== 4'b0100) begin
      errors++;
      $display("FAIL drain_hold: got %b want %b", obs, 4'b0100);
    end
  endtask

  task automatic test_back_to_back();
    logic d;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      d = (k == 1 || k == 2) ? 1'b1 : 1'b0;
      set_in(1'b0, 1'b0, 1'b1, d, 1'b1);
      tick();
      sample();
      checks++;
      if (obs !== {1'b1, d, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got %b want %b", k, obs, {1'b1, d, 1'b1, 1'b1});
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Serve channel 0 so that the tie would favour channel 1 if reset did not restore priority
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    sample();
    checks++;
    if (rdy !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_ready: got %b want %b", rdy, 2'b00);
    end
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    sample();
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_out: got %b want %b", obs, 4'b0000);
    end
    checks++;
    if (rdy !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_tie: got %b want %b", rdy, 2'b10);
    end
    tick();
    sample();
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL mid_reset_after: got %b want %b", obs, 4'b1100);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_priority_idle();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
